// File: rtl/data_sram_responder.sv
// data_sram_responder: memory-side responder for the data SRAM interface.
// One request in flight at a time; byte-strobed writes, registered read data,
// and a single-cycle data_ok pulse LATENCY cycles after the accepting edge.
// Optional feature: define DSRAM_RAND_DELAY_EN to add 0..3 pseudo-random extra
// wait cycles per request (8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5).
module data_sram_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LOAD_BASE = 4'(LATENCY - 1);

  state_t             state, state_next;
  logic [3:0]         cnt, cnt_next;
  logic [3:0]         load_val;
  logic               accept;
  logic [ADDR_W-1:0]  idx;
  logic [31:0]        rdata_r;
  logic [31:0]        mem [2**ADDR_W];
  logic               unused_addr_bits;

  // Word index: byte offset and bits above the array depth are dropped (aliasing).
  assign idx              = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef DSRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Free-running LFSR supplying the extra wait cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign load_val = LOAD_BASE + {2'b00, lfsr[1:0]};
`else
  assign load_val = LOAD_BASE;
`endif

  // State and latency counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Handshake outputs and next-state decode.
  always_comb begin
    addr_ok    = (state != WAIT);
    data_ok    = (state == RESP);
    accept     = req && addr_ok;
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          cnt_next   = load_val;
          state_next = (load_val == 4'd0) ? RESP : WAIT;
        end else if (state == RESP) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte-strobed write into the storage array; contents are never reset.
  always_ff @(posedge clk) begin
    if (accept && wr && !reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read data captured at the accepting edge and held until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              rdata_r <= '0;
    else if (accept && !wr) rdata_r <= mem[idx];
  end

  assign rdata = rdata_r;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: three instances (LATENCY 1, 3, 4)
// share stimulus lines; only the selected instance sees req.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  int          sel;

  logic [2:0]  req_s;
  logic        ao  [3];
  logic        dok [3];
  logic [31:0] rd  [3];

  logic        addr_ok_m, data_ok_m;
  logic [31:0] rdata_m;

  typedef struct {
    int unsigned due;
    logic [31:0] rd;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m   [3][4096];
  logic [31:0] last_rd [3];
  int unsigned cyc = 0;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign req_s[k] = req && (sel == k);
    data_sram_responder #(
      .ADDR_W (12),
      .LATENCY((k == 0) ? 1 : ((k == 1) ? 3 : 4))
    ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req_s[k]),
      .wr     (wr),
      .addr   (addr),
      .wstrb  (wstrb),
      .wdata  (wdata),
      .addr_ok(ao[k]),
      .data_ok(dok[k]),
      .rdata  (rd[k])
    );
  end

  assign addr_ok_m = ao[sel];
  assign data_ok_m = dok[sel];
  assign rdata_m   = rd[sel];

  function automatic int unsigned lat(input int s);
    case (s)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req_v);
    end
  endtask

  // Monitor: pops the scoreboard whenever the selected instance pulses data_ok.
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        fails++;
        $display("FAIL missing_data_ok: none by cycle %0d, expected at %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (data_ok_m) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_data_ok: pulse at cycle %0d with nothing outstanding", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cyc != e.due || rdata_m !== e.rd) begin
            fails++;
            $display("FAIL response: cycle %0d rdata %h, expected cycle %0d rdata %h",
                     cyc, rdata_m, e.due, e.rd);
          end
        end
      end
    end
  end

  // Issue one request, wait (bounded) for acceptance, push the expected response.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int stalls);
    exp_t e;
    int   ix;
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    stalls = 0;
    while (!addr_ok_m && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!addr_ok_m) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: addr_ok %b, expected 1", addr_ok_m);
      req = 1'b0;
      return;
    end
    ix = int'((a >> 2) & 32'hFFF);
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mem_m[sel][ix][8*i +: 8] = d[8*i +: 8];
    end else begin
      last_rd[sel] = mem_m[sel][ix];
    end
    e.rd  = last_rd[sel];
    e.due = cyc + lat(sel);
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    req = 1'b0;
    while (q.size() > 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int st, st2, pulses;
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wstrb = '0; wdata = '0; sel = 0;
    for (int k = 0; k < 3; k++) last_rd[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_addr_ok", {31'b0, ao[k]}, 32'd1);
      check("reset_data_ok", {31'b0, dok[k]}, 32'd0);
      check("reset_rdata", rd[k], 32'h0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: LATENCY=1 write then read.
    sel = 0;
    do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, st);
    check("t1_write_accept_stalls", st, 32'd0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, st);
    check("t1_read_accept_stalls", st, 32'd0);
    drain();
    check("t1_rdata_held", rdata_m, 32'hDEADBEEF);

    // Test 2: byte strobes, then a zero-strobe write that must change nothing.
    do_req(1'b1, 32'h20, 4'hF, 32'h11223344, st);
    do_req(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, st);
    do_req(1'b0, 32'h20, 4'h0, 32'h0, st);
    drain();
    check("t2_strobed_word", rdata_m, 32'h11BB33DD);
    do_req(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, st);
    do_req(1'b0, 32'h23, 4'h0, 32'h0, st);
    drain();
    check("t2_zero_strobe", rdata_m, 32'h11BB33DD);

    // Test 4: back-to-back LATENCY=1 reads with req held high.
    do_req(1'b1, 32'h0, 4'hF, 32'h01010101, st);
    do_req(1'b1, 32'h4, 4'hF, 32'h02020202, st);
    do_req(1'b1, 32'h8, 4'hF, 32'h03030303, st);
    drain();
    do_req(1'b0, 32'h0, 4'h0, 32'h0, st);
    check("t4_b2b_stall0", st, 32'd0);
    do_req(1'b0, 32'h4, 4'h0, 32'h0, st);
    check("t4_b2b_stall1", st, 32'd0);
    do_req(1'b0, 32'h8, 4'h0, 32'h0, st);
    check("t4_b2b_stall2", st, 32'd0);
    drain();

    // Test 5: aliasing of high address bits.
    do_req(1'b1, 32'h0000_4004, 4'hF, 32'hCAFE0001, st);
    do_req(1'b0, 32'h0000_0004, 4'h0, 32'h0, st);
    drain();
    check("t5_alias", rdata_m, 32'hCAFE0001);

    // Test 3: LATENCY=4, second request must stall through WAIT.
    sel = 2;
    idle(2);
    do_req(1'b1, 32'h30, 4'hF, 32'h12345678, st);
    drain();
    do_req(1'b0, 32'h30, 4'h0, 32'h0, st);
    do_req(1'b0, 32'h30, 4'h0, 32'h0, st2);
    check("t3_wait_stalls", st2, 32'd3);
    drain();
    check("t3_rdata", rdata_m, 32'h12345678);

    // Test 6: async reset during WAIT at LATENCY=3.
    sel = 1;
    idle(2);
    do_req(1'b1, 32'h40, 4'hF, 32'h5A5AA5A5, st);
    drain();
    do_req(1'b0, 32'h40, 4'h0, 32'h0, st);
    @(negedge clk);
    req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t6_reset_addr_ok", {31'b0, addr_ok_m}, 32'd1);
    check("t6_reset_data_ok", {31'b0, data_ok_m}, 32'd0);
    check("t6_reset_rdata", rdata_m, 32'h0);
    q.delete();
    for (int k = 0; k < 3; k++) last_rd[k] = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (data_ok_m) pulses++;
    end
    check("t6_no_pulse_after_reset", pulses, 32'd0);
    check("t6_rdata_after_reset", rdata_m, 32'h0);
    do_req(1'b0, 32'h40, 4'h0, 32'h0, st);
    drain();
    check("t6_write_kept", rdata_m, 32'h5A5AA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
